// File: rtl/rca_word_sched_if.sv
// Bundle of request, response and RCA-side signals for rca_word_sched.
// The slave modport is the sequencer's view; the master modport is the
// environment (requesters, consumer and the external 4-bit adder).
interface rca_word_sched_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_sub;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_sub;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_ovf;

    logic [3:0]   rca_a;
    logic [3:0]   rca_b;
    logic         rca_cin;
    logic [3:0]   rca_s;
    logic         rca_cout;

    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
        input  rsp_ready,
        output rca_a, rca_b, rca_cin,
        input  rca_s, rca_cout,
        output busy
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
        output rsp_ready,
        input  rca_a, rca_b, rca_cin,
        output rca_s, rca_cout,
        input  busy
    );
endinterface

// File: rtl/rca_word_sched.sv
// Round-robin sequencer for a shared external 4-bit ripple-carry adder.
// Accepts one W-bit add/sub from either requester, streams it LSB nibble
// first through the adder with a registered carry, and holds the result
// (sum, carry-out, signed overflow) on a valid/ready response channel.
module rca_word_sched #(
    parameter int NIBBLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    rca_word_sched_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic          carry_reg;
    logic [W-1:0]  sum_reg;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          sub_reg;
    logic          id_reg;
    logic          last_grant;
    logic          rsp_valid_r;
    logic          rsp_cout_r;
    logic          rsp_ovf_r;
    logic          busy_r;
    logic          grant0;
    logic          grant1;

    // Two's-complement overflow: like-signed operands producing a result of
    // the other sign. b_msb is the effective (possibly inverted) operand MSB.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

    // Arbitration: only in IDLE and never while reset is asserted; on a tie
    // the requester that did not win last time is granted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = last_grant;
                grant1 = !last_grant;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    // Control FSM: accept, step through nibbles, hold the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            carry_reg   <= 1'b0;
            sum_reg     <= '0;
            last_grant  <= 1'b1;
            id_reg      <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_cout_r  <= 1'b0;
            rsp_ovf_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        id_reg     <= grant1;
                        last_grant <= grant1;
                        carry_reg  <= grant1 ? bus.req1_sub : bus.req0_sub;
                        idx        <= '0;
                        busy_r     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_reg[4*idx +: 4] <= bus.rca_s;
                    carry_reg           <= bus.rca_cout;
                    if (idx == LAST_IDX) begin
                        rsp_valid_r <= 1'b1;
                        rsp_cout_r  <= bus.rca_cout;
                        rsp_ovf_r   <= ovf_calc(a_reg[W-1], b_reg[W-1] ^ sub_reg,
                                                bus.rca_s[3]);
                        state       <= RESP;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand capture on the acceptance edge; held until the next grant.
    always_ff @(posedge clk) begin
        if (grant0 || grant1) begin
            a_reg   <= grant1 ? bus.req1_a   : bus.req0_a;
            b_reg   <= grant1 ? bus.req1_b   : bus.req0_b;
            sub_reg <= grant1 ? bus.req1_sub : bus.req0_sub;
        end
    end

    // Adder drive: current nibble in RUN (B inverted for subtract), else 0.
    always_comb begin
        bus.rca_a   = 4'h0;
        bus.rca_b   = 4'h0;
        bus.rca_cin = 1'b0;
        if (state == RUN) begin
            bus.rca_a   = a_reg[4*idx +: 4];
            bus.rca_b   = b_reg[4*idx +: 4] ^ {4{sub_reg}};
            bus.rca_cin = carry_reg;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.rsp_valid  = rsp_valid_r;
    assign bus.rsp_id     = id_reg;
    assign bus.rsp_sum    = sum_reg;
    assign bus.rsp_cout   = rsp_cout_r;
    assign bus.rsp_ovf    = rsp_ovf_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_rca_word_sched.sv
// Directed bench for rca_word_sched with a behavioural 4-bit RCA attached.
module tb_rca_word_sched;
    localparam int NIBBLES = 4;
    localparam int W = 4 * NIBBLES;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rca_word_sched_if #(.NIBBLES(NIBBLES)) bus ();

    rca_word_sched #(.NIBBLES(NIBBLES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // External combinational ripple-carry adder.
    assign {bus.rca_cout, bus.rca_s} = {1'b0, bus.rca_a} + {1'b0, bus.rca_b}
                                     + {4'b0000, bus.rca_cin};

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp_v);
        nvec++;
        if (obs !== exp_v) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and wait (bounded) until it is accepted.
    task automatic issue(input int who, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sub);
        bit ok;
        ok = 1'b0;
        if (who == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_valid = 1'b1;
        end
        #1;
        for (int i = 0; i < 30 && !ok; i++) begin
            if ((who == 0) ? bus.req0_ready : bus.req1_ready) ok = 1'b1;
            tick();
        end
        if (who == 0) bus.req0_valid = 1'b0;
        else          bus.req1_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    // Count cycles until rsp_valid; readies must stay low while busy.
    task automatic wait_rsp(output int cycles);
        cycles = 0;
        while (!bus.rsp_valid && cycles < 30) begin
            if (bus.busy)
                chk("ready_while_busy", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            chk("both_ready", 32'(bus.req0_ready & bus.req1_ready), 32'd0);
            tick();
            cycles++;
        end
    endtask

    task automatic run_op(input string tag, input int who,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic sub, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
        int c;
        issue(who, a, b, sub);
        wait_rsp(c);
        chk({tag, "_lat"},  c, 32'd4);
        chk({tag, "_sum"},  32'(bus.rsp_sum), 32'(esum));
        chk({tag, "_cout"}, 32'(bus.rsp_cout), 32'(ecout));
        chk({tag, "_ovf"},  32'(bus.rsp_ovf), 32'(eovf));
        chk({tag, "_id"},   32'(bus.rsp_id), who);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk({tag, "_drop"}, {30'd0, bus.rsp_valid, bus.busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c;
        bit  seen;
        bus.req0_valid = 1'b1; bus.req0_a = '0; bus.req0_b = '0; bus.req0_sub = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = '0; bus.req1_b = '0; bus.req1_sub = 1'b0;
        bus.rsp_ready  = 1'b0;

        // Reset held two cycles with both requesters valid.
        tick();
        tick();
        chk("rst_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_cout, bus.rsp_ovf}, 32'd0);
        chk("rst_id_sum", {15'd0, bus.rsp_id, bus.rsp_sum}, 32'd0);
        chk("rst_rca", {23'd0, bus.rca_a, bus.rca_b, bus.rca_cin}, 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        tick();

        run_op("add",   0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("wrap",  1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("povf",  0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub",   1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("subov", 0, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: response held 3 cycles while requester 0 waits.
        issue(1, 16'h1234, 16'h0FFF, 1'b0);
        wait_rsp(c);
        bus.req0_a = 16'h0101; bus.req0_b = 16'h0202; bus.req0_sub = 1'b0;
        bus.req0_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_sum", 32'(bus.rsp_sum), 32'h2233);
            chk("bp_id", 32'(bus.rsp_id), 32'd1);
            chk("bp_noaccept", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
            tick();
        end
        bus.req0_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        chk("bp_release", 32'(bus.rsp_valid), 32'd0);

        // Arbitration from a fresh reset: grants must alternate 0,1,0,1.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req0_a = 16'h1111; bus.req0_b = 16'h2222; bus.req0_sub = 1'b0;
        bus.req1_a = 16'h9000; bus.req1_b = 16'h1000; bus.req1_sub = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_rsp(c);
            chk("arb_id", 32'(bus.rsp_id), k % 2);
            chk("arb_sum", 32'(bus.rsp_sum), (k % 2 == 0) ? 32'h3333 : 32'h8000);
            chk("arb_cout", 32'(bus.rsp_cout), (k % 2 == 0) ? 32'd0 : 32'd1);
            bus.rsp_ready = 1'b1;
            tick();
            bus.rsp_ready = 1'b0;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();

        // Abort: reset pulse while nibble 2 is on the adder.
        issue(0, 16'h1234, 16'h0FFF, 1'b0);
        tick();
        tick();
        chk("abort_nib2", 32'(bus.rca_a), 32'h2);
        rst = 1'b1;
        #1;
        chk("abort_idle", {30'd0, bus.busy, bus.rsp_valid}, 32'd0);
        chk("abort_rca", 32'(bus.rca_a), 32'd0);
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.rsp_valid) seen = 1'b1;
        end
        chk("abort_norsp", 32'(seen), 32'd0);
        run_op("post", 0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/rca_word_sched.md
# rca_word_sched

Sequencer and arbiter for the shared 4-bit ripple-carry adder (RCA). Two requesters submit multi-nibble add/subtract operations. The block grants one requester round-robin and streams the operands through the external 4-bit RCA one nibble per clock, least-significant nibble first, chaining the carry in a register. It returns the full-width result with carry-out and signed overflow over a valid/ready response channel.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand; word width W = 4*NIBBLES (NIBBLES >= 2).
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation pending.
- req0_ready  output  1  requester 0 operation accepted on this edge if valid.
- req0_a, req0_b  input  W  operands of requester 0.
- req0_sub  input  1  1 = compute A-B; 0 = compute A+B.
- req1_valid / req1_ready / req1_a / req1_b / req1_sub: same as requester 0, for requester 1.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer takes the result.
- rsp_id  output  1  index of the requester that owns the result.
- rsp_sum  output  W  result word.
- rsp_cout  output  1  carry out of the MSB nibble. For subtraction, 1 means no borrow.
- rsp_ovf  output  1  two's-complement overflow.
- rca_a, rca_b  output  4  nibble operands to the RCA.
- rca_cin  output  1  carry into the RCA.
- rca_s  input  4  RCA sum (combinational from rca_a/rca_b/rca_cin).
- rca_cout  input  1  RCA carry out.
- busy  output  1  high in RUN or RESP.

## Operation
- States: IDLE, RUN, RESP. Reset puts the block in IDLE.
- Reset values: every output 0, idx 0, carry_reg 0, sum_reg 0, last_grant 1 (requester 0 wins the first tie).
- **IDLE, arbitration:**
  - Only one valid requester: it gets ready=1.
  - Both valid: the requester other than last_grant gets ready=1.
  - No ready is asserted outside IDLE, and at most one ready is high at any time.
- **IDLE, acceptance edge:**
  - Latch a_reg, b_reg, sub_reg, id_reg.
  - carry_reg <= sub; idx <= 0; last_grant <= granted id.
  - Go to RUN.
- **RUN, combinational drive:**
  - rca_a = a_reg[4*idx+:4].
  - rca_b = b_reg[4*idx+:4] XOR {4{sub_reg}}.
  - rca_cin = carry_reg.
- **RUN, each edge:**
  - sum_reg[4*idx+:4] <= rca_s; carry_reg <= rca_cout; idx <= idx+1.
  - On the edge where idx == NIBBLES-1, go to RESP instead of incrementing idx.
- Outside RUN, rca_a, rca_b and rca_cin are 0.
- Overflow, computed when entering RESP:
  - rsp_ovf = (a_msb == beff_msb) && (sum_msb != a_msb).
  - beff_msb = b_reg[W-1] ^ sub_reg; sum_msb is the new sum MSB written on that edge.
- **RESP:**
  - rsp_valid = 1; rsp_sum, rsp_cout, rsp_ovf and rsp_id are stable while rsp_valid is high.
  - On the edge with rsp_ready = 1, go to IDLE.
  - rsp_valid may stay high indefinitely (backpressure). No new request is accepted while in RESP.
- Reset at any point, including mid-RUN or in RESP: return to IDLE immediately, drop the in-flight operation, emit no response.

## Timing
- Acceptance at edge T (valid & ready).
- Nibble k is presented to the RCA during the cycle after edge T+k (k = 0..NIBBLES-1) and captured at edge T+k+1.
- rsp_valid rises after edge T+NIBBLES: latency of NIBBLES cycles from acceptance.
- If rsp_ready is high in the first RESP cycle, IDLE is reached after edge T+NIBBLES+1. The next acceptance is at edge T+NIBBLES+2 at the earliest.
- Minimum initiation interval: NIBBLES+2 cycles.
- Under continuous contention, grants alternate 0,1,0,1…
- A requester dropping valid in IDLE before acceptance is simply not granted; no state changes.

## Test plan
- **Reset:** assert rst for 2 cycles with both valids high → all outputs 0, state IDLE, no ready during reset.
- **Add (NIBBLES=4):** req0 0x1234 + 0x0FFF → rsp_sum 0x2233, cout 0, ovf 0, rsp_id 0. rsp_valid exactly 4 cycles after acceptance.
- **Carry chain / wrap:** 0xFFFF + 0x0001 → 0x0000, cout 1, ovf 0. Separately, 0x7FFF + 0x0001 → 0x8000, cout 0, ovf 1.
- **Subtract:** 0x0005 - 0x0007 → 0xFFFE, cout 0, ovf 0. Separately, 0x8000 - 0x0001 → 0x7FFF, cout 1, ovf 1.
- **Arbitration:** both requesters valid continuously with distinct operands → grant order 0,1,0,1. rsp_id matches each result, and no ready is asserted outside IDLE.
- **Backpressure and abort:**
  - rsp_ready held low 3 cycles in RESP → outputs stable, no acceptance.
  - rst pulsed during RUN nibble 2 → IDLE, rsp_valid never asserts for that operation, next request completes correctly.
